// File: rtl/dmem_lsu.sv
// Load/store unit on the data port of the word-organised BRAM: turns one byte/half/word
// request into a word access with byte lanes, and aligns/extends load data on the way back.
module dmem_lsu #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [3:0]            mem_byte_sel,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data_in,
  input  logic [31:0]           mem_data_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t                state_q, state_d;
  logic                  we_q, unsigned_q, err_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q, rdata_q;

  logic                  accept, misaligned, issue;
  logic [3:0]            byte_sel;
  logic [31:0]           store_data, shifted, load_data;

  assign accept = (state_q == IDLE) && req_valid;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    misaligned = 1'b1;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = misaligned ? RESP : ISSUE;
      ISSUE:   state_d = we_q ? RESP : CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request fields are captured only on the accept edge; rdata_q is cleared there so
  // store and error responses report zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else if (accept) begin
      we_q       <= req_we;
      unsigned_q <= req_unsigned;
      err_q      <= misaligned;
      size_q     <= req_size;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      rdata_q    <= '0;
    end else if (state_q == CAPTURE) begin
      rdata_q    <= load_data;
    end
  end

  always_comb begin
    byte_sel   = 4'b1111;
    store_data = wdata_q;
    case (size_q)
      2'b00: begin
        byte_sel   = 4'b0001 << addr_q[1:0];
        store_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_sel   = addr_q[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata_q[15:0]}};
      end
      default: begin
        byte_sel   = 4'b1111;
        store_data = wdata_q;
      end
    endcase
  end

  // Shifting the read word down by the byte offset puts the addressed byte or half in
  // the low bits; aligned accesses make that valid for every size.
  assign shifted = mem_data_out >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = shifted;
    case (size_q)
      2'b00:   load_data = {{24{~unsigned_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{~unsigned_q & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign issue        = (state_q == ISSUE);
  assign req_ready    = (state_q == IDLE) && reset;
  assign mem_wen      = issue && we_q;
  assign mem_ren      = issue && !we_q;
  assign mem_byte_sel = issue ? byte_sel : 4'b0000;
  assign mem_address  = issue ? addr_q[ADDR_WIDTH+1:2] : '0;
  assign mem_data_in  = (issue && we_q) ? store_data : '0;

  assign rsp_valid    = (state_q == RESP);
  assign rsp_rdata    = rsp_valid ? rdata_q : '0;
  assign rsp_error    = rsp_valid && err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: byte-level memory model predicts every output cycle by cycle,
// with directed literal cases, back-to-back traffic, mid-load reset and random traffic.
module tb_dmem_lsu;

  localparam int AW     = 11;
  localparam int NW     = 1 << AW;
  localparam int NBYTES = 4 * NW;

  logic          clk, reset;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_error, mem_ren, mem_wen;
  logic [31:0]   rsp_rdata, mem_data_in, mem_data_out;
  logic [3:0]    mem_byte_sel;
  logic [AW-1:0] mem_address;

  dmem_lsu #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_byte_sel(mem_byte_sel),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  // Environment BRAM: byte-lane writes, registered read.
  logic        bram_init;
  logic [31:0] bram [0:NW-1];
  always @(posedge clk) begin
    if (bram_init) begin
      for (int i = 0; i < NW; i++) bram[i] <= init_word(i);
    end else begin
      if (mem_wen)
        for (int i = 0; i < 4; i++)
          if (mem_byte_sel[i]) bram[mem_address][8*i +: 8] <= mem_data_in[8*i +: 8];
      if (mem_ren) mem_data_out <= bram[mem_address];
    end
  end

  // Reference model: flat byte array plus per-cycle expected outputs.
  logic [7:0] ref_mem [0:NBYTES-1];

  typedef struct {
    logic          ready, ren, wen, rvalid, rerr, chk_addr, chk_din;
    logic [3:0]    bsel;
    logic [AW-1:0] addr;
    logic [31:0]   din, rdata;
  } exp_t;

  exp_t exp_q [$];
  exp_t cmp_e;

  int n_checks = 0, n_pass = 0;
  int rsp_cnt = 0, mem_act = 0, acc_cnt = 0, n_req = 0;
  logic cmp_en;
  int obs_rsp_k;
  logic [31:0] obs_rdata, obs_din;
  logic        obs_err;
  logic [3:0]  obs_bsel;
  logic [AW-1:0] obs_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t blank();
    exp_t r;
    r.ready = 1'b0; r.ren = 1'b0; r.wen = 1'b0; r.rvalid = 1'b0; r.rerr = 1'b0;
    r.chk_addr = 1'b0; r.chk_din = 1'b0; r.bsel = 4'b0; r.addr = '0;
    r.din = 32'h0; r.rdata = 32'h0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      if (exp_q.size() != 0) cmp_e = exp_q.pop_front();
      else begin
        cmp_e = blank();
        cmp_e.ready = 1'b1;
      end
      check("req_ready", 32'(req_ready), 32'(cmp_e.ready));
      check("mem_ren", 32'(mem_ren), 32'(cmp_e.ren));
      check("mem_wen", 32'(mem_wen), 32'(cmp_e.wen));
      check("mem_byte_sel", 32'(mem_byte_sel), 32'(cmp_e.bsel));
      check("rsp_valid", 32'(rsp_valid), 32'(cmp_e.rvalid));
      check("rsp_rdata", rsp_rdata, cmp_e.rdata);
      check("rsp_error", 32'(rsp_error), 32'(cmp_e.rerr));
      if (cmp_e.chk_addr) check("mem_address", 32'(mem_address), 32'(cmp_e.addr));
      if (cmp_e.chk_din) check("mem_data_in", mem_data_in, cmp_e.din);
    end
  end

  always @(negedge clk) begin
    if (rsp_valid) rsp_cnt++;
    if (mem_ren || mem_wen) mem_act++;
    if (req_valid && req_ready) acc_cnt++;
  end

  task automatic scramble();
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = (AW+2)'($urandom);
    req_wdata    = $urandom;
  endtask

  // Called at posedge+#1 of an idle cycle; returns at posedge+#1 of the next idle cycle.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [AW+1:0] addr, input logic [31:0] wdata, input bit hold);
    exp_t r;
    int a, n, len, off;
    logic [31:0] v;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    a = int'(addr);
    n = 1 << size;
    off = a % 4;
    n_req++;
    r = blank(); r.ready = 1'b1; exp_q.push_back(r);
    if (size == 2'b11 || (a % n) != 0) begin
      r = blank(); r.rvalid = 1'b1; r.rerr = 1'b1; exp_q.push_back(r);
      len = 2;
    end else begin
      r = blank();
      r.chk_addr = 1'b1;
      r.addr = AW'(a / 4);
      for (int i = 0; i < 4; i++) r.bsel[i] = (i >= off) && (i < off + n);
      if (we) begin
        r.wen = 1'b1;
        r.chk_din = 1'b1;
        for (int i = 0; i < 4; i++) r.din[8*i +: 8] = wdata[8*(i % n) +: 8];
        exp_q.push_back(r);
        for (int j = 0; j < n; j++) ref_mem[a + j] = wdata[8*j +: 8];
        r = blank(); r.rvalid = 1'b1; exp_q.push_back(r);
        len = 3;
      end else begin
        r.ren = 1'b1;
        exp_q.push_back(r);
        r = blank(); exp_q.push_back(r);
        v = 32'h0;
        for (int j = 0; j < n; j++) v[8*j +: 8] = ref_mem[a + j];
        if (!uns && n < 4 && v[8*n-1])
          for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
        r = blank(); r.rvalid = 1'b1; r.rdata = v; exp_q.push_back(r);
        len = 4;
      end
    end
    obs_rsp_k = -1;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k == 1) begin
        obs_bsel = mem_byte_sel; obs_addr = mem_address; obs_din = mem_data_in;
      end
      if (rsp_valid && obs_rsp_k < 0) begin
        obs_rsp_k = k; obs_rdata = rsp_rdata; obs_err = rsp_error;
      end
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
      scramble();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req_ready"}, 32'(req_ready), 32'h0);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
    check({tag, " rsp_error"}, 32'(rsp_error), 32'h0);
    check({tag, " mem_ren"}, 32'(mem_ren), 32'h0);
    check({tag, " mem_wen"}, 32'(mem_wen), 32'h0);
    check({tag, " mem_byte_sel"}, 32'(mem_byte_sel), 32'h0);
    check({tag, " mem_address"}, 32'(mem_address), 32'h0);
    check({tag, " mem_data_in"}, mem_data_in, 32'h0);
  endtask

  initial begin
    logic [31:0] w;
    logic [AW+1:0] ra;
    logic [1:0] rs;
    int m0, a0, r0;
    bit hold;

    reset = 1'b0; cmp_en = 1'b0; bram_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = 32'h0;
    for (int i = 0; i < NW; i++) begin
      w = init_word(i);
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end
    #3;
    check_all_zero("reset");
    @(posedge clk); @(posedge clk); #1 bram_init = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1 cmp_en = 1'b1;

    // Word store then load.
    do_req(1'b1, 2'b10, 1'b0, 13'h010, 32'hDEADBEEF, 1'b0);
    check("st_word addr", 32'(obs_addr), 32'd4);
    check("st_word bsel", 32'(obs_bsel), 32'hF);
    check("st_word din", obs_din, 32'hDEADBEEF);
    check("st_word rsp_k", 32'(obs_rsp_k), 32'd2);
    do_req(1'b0, 2'b10, 1'b0, 13'h010, 32'h0, 1'b0);
    check("ld_word rdata", obs_rdata, 32'hDEADBEEF);
    check("ld_word err", 32'(obs_err), 32'h0);
    check("ld_word rsp_k", 32'(obs_rsp_k), 32'd3);

    // Byte store / signed and unsigned byte loads.
    do_req(1'b1, 2'b00, 1'b0, 13'h013, 32'h000000A5, 1'b0);
    check("st_byte bsel", 32'(obs_bsel), 32'h8);
    check("st_byte din", obs_din, 32'hA5A5A5A5);
    do_req(1'b0, 2'b00, 1'b0, 13'h013, 32'h0, 1'b0);
    check("ld_sbyte", obs_rdata, 32'hFFFFFFA5);
    do_req(1'b0, 2'b00, 1'b1, 13'h013, 32'h0, 1'b0);
    check("ld_ubyte", obs_rdata, 32'h000000A5);

    // Half loads from the upper half of 0x80017FFF.
    do_req(1'b1, 2'b10, 1'b0, 13'h000, 32'h80017FFF, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 13'h002, 32'h0, 1'b0);
    check("ld_shalf", obs_rdata, 32'hFFFF8001);
    do_req(1'b0, 2'b01, 1'b1, 13'h002, 32'h0, 1'b0);
    check("ld_uhalf", obs_rdata, 32'h00008001);

    // Misaligned and illegal-size requests.
    m0 = mem_act;
    do_req(1'b0, 2'b10, 1'b0, 13'h005, 32'h0, 1'b0);
    check("mis_word rsp_k", 32'(obs_rsp_k), 32'd1);
    check("mis_word err", 32'(obs_err), 32'h1);
    check("mis_word rdata", obs_rdata, 32'h0);
    do_req(1'b1, 2'b01, 1'b0, 13'h001, 32'h1234, 1'b0);
    check("mis_half rsp_k", 32'(obs_rsp_k), 32'd1);
    check("mis_half err", 32'(obs_err), 32'h1);
    do_req(1'b0, 2'b11, 1'b0, 13'h000, 32'h0, 1'b0);
    check("bad_size rsp_k", 32'(obs_rsp_k), 32'd1);
    check("bad_size err", 32'(obs_err), 32'h1);
    check("misaligned mem activity", 32'(mem_act - m0), 32'h0);

    // Back-to-back with req_valid held high.
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++)
      do_req(1'b1, 2'b10, 1'b0, 13'(32 + 4*i), $urandom, i != 3);
    check("b2b store accepts", 32'(acc_cnt - a0), 32'd4);
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++)
      do_req(1'b0, 2'b10, 1'($urandom), 13'(32 + 4*i), 32'h0, i != 3);
    check("b2b load accepts", 32'(acc_cnt - a0), 32'd4);

    // Reset during CAPTURE of a load.
    cmp_en = 1'b0;
    r0 = rsp_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 13'h010;
    @(posedge clk); #1 req_valid = 1'b0;
    check("rst pre ren", 32'(mem_ren), 32'h1);
    @(posedge clk); #2 reset = 1'b0;
    #1 check_all_zero("midrst");
    @(posedge clk); @(posedge clk); #1;
    check("midrst no rsp", 32'(rsp_cnt - r0), 32'h0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("post rst ready", 32'(req_ready), 32'h1);
    cmp_en = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 13'h010, 32'h0, 1'b0);
    check("post rst load rsp_k", 32'(obs_rsp_k), 32'd3);

    // Random traffic.
    for (int it = 0; it < 200; it++) begin
      ra = 13'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) ra = ra | 13'h1F80;
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (rs == 2'b01) ra[0] = 1'b0;
        if (rs == 2'b10) ra[1:0] = 2'b00;
      end
      hold = (it != 199) && ($urandom_range(0, 1) == 1);
      do_req(1'($urandom), rs, 1'($urandom), ra, $urandom, hold);
      if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    check("response count", 32'(rsp_cnt), 32'(n_req));
    check("expect queue drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that acts as the requester on the data port of the word-organised program/data BRAM. It accepts one byte/half/word load or store from the core and converts it into a word address, a 4-bit byte-select vector and lane-replicated write data. For loads it captures the BRAM read word one cycle after issue, then aligns and sign/zero-extends it. Misaligned accesses are rejected with an error response and never reach memory.

## Interface
- ADDR_WIDTH, 11, word-address width of the BRAM data port; the byte address is ADDR_WIDTH+2 bits.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; equals (state==IDLE) & reset.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_WIDTH+2  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_error  out  1  valid with rsp_valid; 1 = misaligned or illegal size.
- mem_ren  out  1  BRAM read enable.
- mem_wen  out  1  BRAM write enable.
- mem_byte_sel  out  4  BRAM byte-select vector; bit i enables byte lane i (bits 8i+7:8i).
- mem_address  out  ADDR_WIDTH  word address = req_addr[ADDR_WIDTH+1:2].
- mem_data_in  out  32  BRAM write data.
- mem_data_out  in  32  BRAM read data, valid the cycle after mem_ren is high.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: req_ready=1. On req_valid, latch we/size/unsigned/addr/wdata. Go to RESP with error set if misaligned; otherwise go to ISSUE.
- Misaligned means: size 11; half with addr[0]=1; word with addr[1:0]!=00.
- ISSUE, which lasts exactly one cycle:
  - mem_address, mem_byte_sel and mem_data_in are driven from registers.
  - A store asserts mem_wen and goes to RESP.
  - A load asserts mem_ren and goes to CAPTURE.
- CAPTURE: sample mem_data_out and register the aligned result, then go to RESP.
- RESP: rsp_valid=1 for one cycle, then go to IDLE. There is no response backpressure.
- Byte select:
  - byte: 0001 << addr[1:0].
  - half: 0011 if addr[1]=0, else 1100.
  - word: 1111.
  - Outside ISSUE, mem_byte_sel=0000.
- Store data lanes: byte replicated to {4{wdata[7:0]}}; half replicated to {2{wdata[15:0]}}; word passed through.
- Load extraction:
  - byte = lane addr[1:0]; half = bits [15:0] or [31:16] selected by addr[1]; word unchanged.
  - Extension to 32 bits uses bit 7 or bit 15, unless req_unsigned=1, in which case upper bits are 0.
- mem_wen and mem_ren are never high together and are high only in ISSUE.

## Timing
- Reset values: state IDLE; req_ready=0 while reset=0; all other outputs 0; all latched fields 0.
- Latency, counted from the accept edge T (req_valid & req_ready sampled high):
  - store: mem_wen high in cycle T+1; rsp_valid in cycle T+2.
  - load: mem_ren high in T+1; data sampled at the end of T+2; rsp_valid with rsp_rdata in T+3.
  - error: rsp_valid and rsp_error in T+1, with no mem_* activity.
- req_ready is low from T+1 until the cycle after RESP. Sustained throughput is one store per 3 cycles and one load per 4 cycles.
- rsp_rdata and rsp_error hold their values only while rsp_valid=1; they are 0 otherwise.
- Asynchronous reset mid-operation aborts the transaction with no response, and mem_wen/mem_ren drop immediately. A store interrupted in ISSUE leaves memory contents undefined for that word.
- req_* inputs are ignored in every state except IDLE. Request fields are latched only on the accept edge, so changing them after acceptance has no effect.

## Test plan
- Word store then load: store 0xDEADBEEF to addr 0x010.
  - Store issue: mem_address=4, byte_sel=1111, mem_wen for 1 cycle, rsp at T+2.
  - Load from the same address: rsp_rdata=0xDEADBEEF at T+3, error 0.
- Byte store at addr 0x013 with wdata=0x000000A5: byte_sel=1000, mem_data_in=0xA5A5A5A5. A signed byte load of 0x013 returns 0xFFFFFFA5; an unsigned byte load returns 0x000000A5.
- Half load at addr 0x002 with mem_data_out=0x80017FFF: signed returns 0xFFFF8001; unsigned returns 0x00008001.
- Misaligned cases: word at 0x005, half at 0x001, and size=11 each give rsp_valid and rsp_error=1 at T+1, rsp_rdata=0, and no mem_ren or mem_wen ever asserted.
- Back-to-back requests with req_valid held high: one accept per 3 cycles for stores and 4 for loads; req_ready is low in ISSUE, CAPTURE and RESP; exactly one rsp_valid per request.
- Reset asserted during CAPTURE of a load: all outputs 0 immediately and no rsp_valid. After release, req_ready=1 on the next cycle and a new load completes normally.
